// File: rtl/demux_1to4_buf_pkg.sv
// demux_1to4_buf_pkg
//   Shared definitions for the 1-to-4 buffered demultiplexer: default data
//   width, channel count, select encodings, slot state encoding and a
//   select-to-one-hot decode helper.
package demux_1to4_buf_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_CH1 = 2'b00;
  localparam logic [1:0] SEL_CH2 = 2'b01;
  localparam logic [1:0] SEL_CH3 = 2'b10;
  localparam logic [1:0] SEL_CH4 = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot channel strobe for a select code; bit k-1 is channel k.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH1: oh = 4'b0001;
      SEL_CH2: oh = 4'b0010;
      SEL_CH3: oh = 4'b0100;
      SEL_CH4: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry output buffer for a single demux channel.
//   Ports:
//     clk_i, rst_n_i  clock, async active-low reset
//     load_i          write data_i into the slot this cycle
//     data_i          word to load
//     ready_i         sink consumes the held word this cycle
//     valid_o         slot holds an undelivered word (registered state)
//     data_o          held word; keeps its last value after draining
module demux_slot
  import demux_1to4_buf_pkg::*;
#(
  parameter int size = DATA_W
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic [size-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [size-1:0] data_o
);

  slot_state_e     state_q, state_d;
  logic [size-1:0] data_q, data_d;

  // The top only asserts load_i when the slot is empty or draining this
  // cycle, so a load never overwrites an undelivered word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) data_d = data_i;
    case (state_q)
      SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (ready_i && !load_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf
//   Routes a valid/ready source stream to one of four buffered channels.
//   Ports:
//     clk_i, rst_n_i           clock, async active-low reset
//     data_i, select_i         source word and destination (00 -> ch1 .. 11 -> ch4)
//     valid_i, ready_o         source handshake; ready_o depends only on select_i
//                              and the selected channel, never on valid_i
//     data_k_o, valid_k_o      per-channel held word and valid
//     ready_k_i                per-channel sink consume
//     busy_o                   any channel holds a word
module demux_1to4_buf
  import demux_1to4_buf_pkg::*;
#(
  parameter int size = DATA_W
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [size-1:0] data_i,
  input  logic [1:0]      select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data_1_o,
  output logic [size-1:0] data_2_o,
  output logic [size-1:0] data_3_o,
  output logic [size-1:0] data_4_o,
  output logic            valid_1_o,
  output logic            valid_2_o,
  output logic            valid_3_o,
  output logic            valid_4_o,
  input  logic            ready_1_i,
  input  logic            ready_2_i,
  input  logic            ready_3_i,
  input  logic            ready_4_i,
  output logic            busy_o
);

  logic [NUM_CH-1:0]           load;
  logic [NUM_CH-1:0]           rdy_in;
  logic [NUM_CH-1:0]           vld;
  logic [NUM_CH-1:0][size-1:0] dout;
  logic                        accept;

  assign rdy_in = {ready_4_i, ready_3_i, ready_2_i, ready_1_i};

  // A full slot can still take a word when its sink drains in the same
  // cycle, giving back-to-back transfers without a bubble.
  always_comb begin
    ready_o = ~vld[select_i] | rdy_in[select_i];
    accept  = valid_i & ready_o;
    load    = accept ? sel_decode(select_i) : '0;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.size(size)) u_slot (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load[g]),
      .data_i  (data_i),
      .ready_i (rdy_in[g]),
      .valid_o (vld[g]),
      .data_o  (dout[g])
    );
  end

  assign {valid_4_o, valid_3_o, valid_2_o, valid_1_o} = vld;
  assign data_1_o = dout[0];
  assign data_2_o = dout[1];
  assign data_3_o = dout[2];
  assign data_4_o = dout[3];
  assign busy_o   = |vld;

endmodule

// File: tb/tb_demux_1to4_buf.sv
module tb_demux_1to4_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  sel_i = '0;
  logic        valid_i = 1'b0;
  logic [3:0]  rdy = '0;
  logic        ready_o, busy_o;
  logic [31:0] dout [4];
  logic        vout [4];

  int tests = 0;
  int fails = 0;

  // Scoreboard: words expected on each channel, plus last word loaded
  // (data output is held after a slot drains).
  logic [31:0] exp_q [4][$];
  logic [31:0] last [4];

  always #5 clk = ~clk;

  demux_1to4_buf #(.size(32)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .data_i    (data_i),
    .select_i  (sel_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_1_o  (dout[0]),
    .data_2_o  (dout[1]),
    .data_3_o  (dout[2]),
    .data_4_o  (dout[3]),
    .valid_1_o (vout[0]),
    .valid_2_o (vout[1]),
    .valid_3_o (vout[2]),
    .valid_4_o (vout[3]),
    .ready_1_i (rdy[0]),
    .ready_2_i (rdy[1]),
    .ready_3_i (rdy[2]),
    .ready_4_i (rdy[3]),
    .busy_o    (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last[k] = '0;
    end
  endtask

  task automatic check_state(input string tag);
    logic any;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any = any | (exp_q[k].size() > 0);
      chk($sformatf("%s_v%0d", tag, k + 1), {31'd0, vout[k]}, {31'd0, exp_q[k].size() > 0});
      chk($sformatf("%s_d%0d", tag, k + 1), dout[k],
          (exp_q[k].size() > 0) ? exp_q[k][0] : last[k]);
    end
    chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, any});
  endtask

  // One cycle: drive at posedge+1, check handshake just before the edge,
  // update the scoreboard, then check registered state after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic [31:0] d, input logic [3:0] r);
    logic exp_rdy;
    valid_i = v; sel_i = s; data_i = d; rdy = r;
    #1;
    exp_rdy = (exp_q[s].size() == 0) || r[s];
    chk({tag, "_ready"}, {31'd0, ready_o}, {31'd0, exp_rdy});
    for (int k = 0; k < 4; k++)
      if (r[k] && exp_q[k].size() > 0) begin
        chk($sformatf("%s_pop%0d", tag, k + 1), dout[k], exp_q[k][0]);
        void'(exp_q[k].pop_front());
      end
    if (v && exp_rdy) begin
      exp_q[s].push_back(d);
      last[s] = d;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    clear_model();
    // Reset held with a word offered: nothing may load, ready_o stays high.
    valid_i = 1'b1; sel_i = 2'b10; data_i = 32'h1234_5678;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_state("rst");
    chk("rst_ready2", {31'd0, ready_o}, 32'd1);
    rst_n = 1'b1;

    // First accept on the first edge after release.
    step("first", 1'b1, 2'b10, 32'h0000_00AA, 4'b0000);
    chk("first_v3", {31'd0, vout[2]}, 32'd1);
    chk("first_d3", dout[2], 32'h0000_00AA);
    step("drain3", 1'b0, 2'b00, 32'h0, 4'b0100);

    // Fill all four channels, then a fifth word to a full channel.
    step("fill1", 1'b1, 2'b00, 32'h11, 4'b0000);
    step("fill2", 1'b1, 2'b01, 32'h22, 4'b0000);
    step("fill3", 1'b1, 2'b10, 32'h33, 4'b0000);
    step("fill4", 1'b1, 2'b11, 32'h44, 4'b0000);
    chk("fill_busy", {31'd0, busy_o}, 32'd1);
    step("fifth", 1'b1, 2'b01, 32'h55, 4'b0000);
    chk("fifth_d2", dout[1], 32'h22);

    // Back-to-back on channel 1.
    step("d1", 1'b0, 2'b00, 32'h0, 4'b0001);
    step("ld5", 1'b1, 2'b00, 32'h5, 4'b0000);
    step("b2b", 1'b1, 2'b00, 32'h6, 4'b0001);
    chk("b2b_v1", {31'd0, vout[0]}, 32'd1);
    chk("b2b_d1", dout[0], 32'h6);

    // Simultaneous drain of channels 2 and 4.
    step("drain24", 1'b0, 2'b00, 32'h0, 4'b1010);
    chk("drain24_v2", {31'd0, vout[1]}, 32'd0);
    chk("drain24_v4", {31'd0, vout[3]}, 32'd0);

    // Spurious: no valid, toggling select, ready on an empty slot.
    step("d3b", 1'b0, 2'b00, 32'h0, 4'b0100);
    for (int s = 0; s < 4; s++)
      step($sformatf("spur%0d", s), 1'b0, 2'(s), 32'hDEAD_BEEF, 4'b0100);

    // Mid-operation reset with slots 1 and 3 full and a word in flight.
    step("ld77", 1'b1, 2'b10, 32'h77, 4'b0000);
    valid_i = 1'b1; sel_i = 2'b01; data_i = 32'hBAD0_0001; rdy = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check_state("midrst");
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    check_state("midrst_edge");
    rst_n = 1'b1;
    step("post", 1'b1, 2'b00, 32'h99, 4'b0000);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_1to4_buf.md
DEMUX_1TO4_BUF -- requirements
Module: demux_1to4_buf

Interface
REQ-001 Parameter: size, default 32, data width in bits of the input and each output.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 data_i  input  size  source data word.
REQ-005 select_i  input  2  destination: 00 -> channel 1, 01 -> 2, 10 -> 3, 11 -> 4.
REQ-006 valid_i  input  1  source offers data_i/select_i this cycle.
REQ-007 ready_o  output  1  block accepts the offered word this cycle.
REQ-008 data_1_o..data_4_o  output  size each  per-channel held data.
REQ-009 valid_1_o..valid_4_o  output  1 each  channel k holds an undelivered word.
REQ-010 ready_1_i..ready_4_i  input  1 each  sink k consumes this cycle.
REQ-011 busy_o  output  1  OR of valid_1_o..valid_4_o.

Function
REQ-012 Each channel k has a one-entry slot with states EMPTY and FULL; valid_k_o = (state == FULL), driven from a register.
REQ-013 Input accept condition: accept = valid_i & ready_o; ready_o = (slot[select_i] EMPTY) | ready_{select_i}_i, combinational.
REQ-014 Latency: a word accepted at edge N appears on data_k_o with valid_k_o=1 from edge N+1 onward.
REQ-015 Slot transitions: EMPTY & accept_k -> FULL, load data_i; FULL & ready_k_i & !accept_k -> EMPTY; FULL & ready_k_i & accept_k -> FULL, load new data_i (back-to-back, no bubble); FULL & !ready_k_i -> FULL, hold.
REQ-016 While valid_k_o=1 and ready_k_i=0, data_k_o shall remain stable.
REQ-017 An accepted word shall be written to exactly one slot, the one named by select_i; other slots unaffected.
REQ-018 valid_i=0 shall cause no slot load regardless of select_i or data_i.
REQ-019 ready_o when valid_i=0 still reflects the currently selected slot (no dependency on valid_i).
REQ-020 Simultaneous drain of several channels in one cycle shall be honoured independently per channel.
REQ-021 ready_k_i asserted with slot EMPTY shall have no effect; no word is lost or duplicated.
REQ-022 When a slot returns to EMPTY, data_k_o keeps its last value (not cleared).

Reset
REQ-023 rst_n_i low shall immediately force all slots EMPTY, valid_1_o..valid_4_o=0, busy_o=0, data_1_o..data_4_o=0.
REQ-024 While rst_n_i is low ready_o shall be 1 and no load occurs; a word in flight at reset assertion is discarded.
REQ-025 The first accept is possible on the first rising edge after rst_n_i is released.

Structure
REQ-026 Shared package holds: default data width (32), channel count (4), select encoding constants, slot state encoding (EMPTY=0, FULL=1).
REQ-027 One sub-module, demux_slot (one-entry buffer with load/drain/valid), instantiated four times; top level holds select decode, ready_o mux and busy_o.

Verification
REQ-028 Reset: hold rst_n_i=0 with valid_i=1 -> all valid_k_o=0, all data_k_o=0, ready_o=1; release, send 0x0000_00AA select 10 -> next cycle valid_3_o=1, data_3_o=0x0000_00AA.
REQ-029 Fill all: send 0x11,0x22,0x33,0x44 to selects 00,01,10,11 with all ready_k_i=0 -> all valid_k_o=1, busy_o=1; fifth word to select 01 -> ready_o=0, data_2_o stays 0x22.
REQ-030 Back-to-back: channel 1 FULL with 0x5, ready_1_i=1, send 0x6 select 00 -> ready_o=1, next cycle valid_1_o=1, data_1_o=0x6.
REQ-031 Drain: channels 2 and 4 FULL, assert ready_2_i and ready_4_i same cycle, valid_i=0 -> next cycle valid_2_o=valid_4_o=0, channels 1,3 unchanged.
REQ-032 Spurious: valid_i=0 with select_i toggling and data_i=0xDEAD_BEEF; ready_3_i=1 on empty slot -> no valid_k_o change.
REQ-033 Mid-operation reset: slots 1 and 3 FULL, assert rst_n_i=0 between edges -> valid_1_o, valid_3_o drop immediately, data zeroed.
